// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: parity mode, FSM states
// and the parity-bit calculation.
package uart_pkg;

  localparam int unsigned MAX_DATA_BITS = 9;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    ODD  = 2'd1,
    EVEN = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  // Callers zero-extend narrower words, which leaves the XOR unchanged.
  function automatic logic par_bit(input logic [MAX_DATA_BITS-1:0] data, input parity_t mode);
    logic x;
    x = ^data;
    return (mode == ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_tx_ext_if.sv
// Host-side stream, divisor and status bundle for the UART transmitter.
interface uart_tx_ext_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DIV_W-1:0]     baud_div;
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 out_txd;
  logic                 out_busy;
  logic [LVL_W-1:0]     out_level;

  modport master (
    output baud_div, in_data, in_valid,
    input  in_ready, out_txd, out_busy, out_level
  );

  modport slave (
    input  baud_div, in_data, in_valid,
    output in_ready, out_txd, out_busy, out_level
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with a combinational head word; the caller guarantees
// push only when not full and pop only when not empty.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  assign dout  = mem[rptr[AW-1:0]];
  assign level = wptr - rptr;

endmodule

// File: rtl/uart_tx_ext.sv
// UART transmitter: buffers words from a ready/valid stream and serialises
// them LSB first with optional parity and 1 or 2 stop bits.
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst_n,
  uart_tx_ext_if.slave bus
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
  localparam parity_t     PMODE = parity_t'(2'(PARITY));

  logic                 push_c;
  logic                 pop_c;
  logic                 load_c;
  logic                 empty_c;
  logic [DATA_BITS-1:0] head;
  logic [LVL_W-1:0]     level;
  logic [LVL_W-1:0]     level_nxt;

  tx_state_t            state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     baud_q, baud_d;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;

  assign bus.in_ready = (level < LVL_W'(FIFO_DEPTH));
  assign push_c       = bus.in_valid && bus.in_ready;
  assign empty_c      = (level == '0);
  assign level_nxt    = level + LVL_W'(push_c) - LVL_W'(pop_c);

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .din   (bus.in_data),
    .dout  (head),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  // txd is computed for the state being entered so the line is a clean flop.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    pop_c   = 1'b0;
    load_c  = 1'b0;

    unique case (state_q)
      IDLE: begin
        txd_d  = 1'b1;
        load_c = !empty_c;
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          baud_d  = div_q;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = div_q;
          if (bit_q == CNT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + CNT_W'(1);
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      PAR: begin
        if (baud_q == '0) begin
          baud_d  = div_q;
          state_d = STOP;
          txd_d   = 1'b1;
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (bit_q == CNT_W'(STOP_BITS - 1)) begin
            if (!empty_c) begin
              load_c = 1'b1;
            end else begin
              state_d = IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d  = bit_q + CNT_W'(1);
            baud_d = div_q;
          end
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Pop the head word and start a frame; the divisor is captured only here.
    if (load_c) begin
      pop_c   = 1'b1;
      shift_d = head;
      par_d   = par_bit(MAX_DATA_BITS'(head), PMODE);
      div_d   = bus.baud_div;
      baud_d  = bus.baud_div;
      state_d = START;
      txd_d   = 1'b0;
    end

    busy_d = (state_d != IDLE) || (level_nxt != '0);
  end

  assign bus.out_txd   = txd_q;
  assign bus.out_busy  = busy_q;
  assign bus.out_level = level;

endmodule

// File: tb/tb_uart_tx_ext.sv
// Scoreboard bench: expected frames are queued at push time and a per-line
// monitor decodes txd cycle by cycle against them.
module tb_uart_tx_ext;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          cpb;
    bit          contig;
    logic [8:0]  data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] din  [3];
  logic       vld  [3];
  logic [15:0] baud [3];
  logic [2:0] txd_v, rdy_v, busy_v;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  uart_tx_ext_if #(.DATA_BITS(8), .DIV_W(16), .FIFO_DEPTH(4)) bus_a ();
  uart_tx_ext_if #(.DATA_BITS(7), .DIV_W(16), .FIFO_DEPTH(4)) bus_b ();
  uart_tx_ext_if #(.DATA_BITS(8), .DIV_W(16), .FIFO_DEPTH(4)) bus_c ();

  assign bus_a.baud_div = baud[0];
  assign bus_a.in_data  = din[0][7:0];
  assign bus_a.in_valid = vld[0];
  assign bus_b.baud_div = baud[1];
  assign bus_b.in_data  = din[1][6:0];
  assign bus_b.in_valid = vld[1];
  assign bus_c.baud_div = baud[2];
  assign bus_c.in_data  = din[2][7:0];
  assign bus_c.in_valid = vld[2];

  assign txd_v  = {bus_c.out_txd,  bus_b.out_txd,  bus_a.out_txd};
  assign rdy_v  = {bus_c.in_ready, bus_b.in_ready, bus_a.in_ready};
  assign busy_v = {bus_c.out_busy, bus_b.out_busy, bus_a.out_busy};

  uart_tx_ext #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  uart_tx_ext #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  uart_tx_ext #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .DIV_W(16), .FIFO_DEPTH(4))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  function automatic int q_size(input int idx);
    case (idx)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void q_push(input int idx, input exp_t e);
    case (idx)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic exp_t q_pop(input int idx);
    case (idx)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Frame = start 0, data LSB first, optional hand-computed parity, stop 1s.
  function automatic exp_t mk(input logic [8:0] d, input int dbits, input bit par_en,
                              input logic par, input int stops, input int cpb, input bit contig);
    exp_t e;
    int   n;
    e.bits = '0;
    n = 1;
    for (int i = 0; i < dbits; i++) begin
      e.bits[n] = d[i];
      n++;
    end
    if (par_en) begin
      e.bits[n] = par;
      n++;
    end
    for (int s = 0; s < stops; s++) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.nbits  = n;
    e.cpb    = cpb;
    e.contig = contig;
    e.data   = d;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Holds valid until accepted; returns #1 after the accepting edge.
  task automatic push(input int idx, input logic [8:0] d);
    int n;
    @(negedge clk);
    din[idx] = d;
    vld[idx] = 1'b1;
    n = 0;
    while (!rdy_v[idx] && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 32'(rdy_v[idx]), 32'd1);
    @(posedge clk);
    #1 vld[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, input int budget);
    int n;
    n = 0;
    while ((q_size(idx) != 0 || busy_v[idx]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(q_size(idx) == 0 && !busy_v[idx]), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic mon(input int idx);
    exp_t e;
    int   gap, bad, first;
    bit   abort;
    forever begin
      gap = 0;
      @(negedge clk);
      while (!(rst_n && txd_v[idx] == 1'b0)) begin
        gap++;
        @(negedge clk);
      end
      if (q_size(idx) == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame[%0d]: start bit seen, no frame expected", idx);
        while (rst_n && txd_v[idx] == 1'b0) @(negedge clk);
        continue;
      end
      e = q_pop(idx);
      if (e.contig) begin
        n_checks++;
        if (gap != 0) begin
          n_fail++;
          $display("FAIL contig[%0d] data %0h: idle gap %0d cycles, expected 0", idx, e.data, gap);
        end
      end
      bad   = 0;
      first = -1;
      abort = 1'b0;
      for (int k = 0; k < e.nbits * e.cpb; k++) begin
        if (k > 0) @(negedge clk);
        if (!rst_n) begin
          abort = 1'b1;
          break;
        end
        if (txd_v[idx] !== e.bits[k / e.cpb]) begin
          bad++;
          if (first < 0) first = k;
        end
      end
      if (!abort) begin
        n_checks++;
        if (bad != 0) begin
          n_fail++;
          $display("FAIL frame[%0d] data %0h: %0d wrong samples, first at cycle %0d, expected bits %0h at %0d cycles/bit",
                   idx, e.data, bad, first, e.bits, e.cpb);
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad;
    for (int i = 0; i < 3; i++) begin
      din[i]  = '0;
      vld[i]  = 1'b0;
      baud[i] = 16'd0;
    end
    repeat (3) @(negedge clk);
    check("rst_txd",   32'(bus_a.out_txd),   32'd1);
    check("rst_level", 32'(bus_a.out_level), 32'd0);
    check("rst_ready", 32'(bus_a.in_ready),  32'd1);
    check("rst_busy",  32'(bus_a.out_busy),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Even parity 0xA5 at 4 cycles/bit, with latency and busy timing.
    baud[0] = 16'd3;
    q_push(0, mk(9'h0A5, 8, 1'b1, 1'b0, 1, 4, 1'b0));
    @(negedge clk);
    din[0] = 9'h0A5;
    vld[0] = 1'b1;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    check("busy_rise",   32'(bus_a.out_busy),  32'd1);
    check("level_push",  32'(bus_a.out_level), 32'd1);
    check("txd_idle_t",  32'(bus_a.out_txd),   32'd1);
    @(posedge clk);
    #1;
    check("start_latency", 32'(bus_a.out_txd),   32'd0);
    check("level_popped",  32'(bus_a.out_level), 32'd0);
    cyc = 0;
    while (bus_a.out_busy && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("even_frame_len", 32'(cyc), 32'd44);
    check("txd_after", 32'(bus_a.out_txd), 32'd1);
    wait_done(0, 50);

    // Odd parity, 7 data bits: 0x03 has two ones, so parity bit is 1.
    baud[1] = 16'd2;
    q_push(1, mk(9'h003, 7, 1'b1, 1'b1, 1, 3, 1'b0));
    push(1, 9'h003);
    wait_done(1, 100);

    // Two stop bits, no parity, 1 cycle/bit: busy covers pop cycle + 11.
    baud[2] = 16'd0;
    q_push(2, mk(9'h0FF, 8, 1'b0, 1'b0, 2, 1, 1'b0));
    push(2, 9'h0FF);
    cyc = 0;
    while (bus_c.out_busy && cyc < 100) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("stop2_busy_len", 32'(cyc), 32'd12);
    wait_done(2, 50);

    // Burst behind a lead frame: 0x11..0x44 fill the FIFO, 0x55 waits for a pop.
    baud[0] = 16'd1;
    q_push(0, mk(9'h001, 8, 1'b1, 1'b1, 1, 2, 1'b0));
    push(0, 9'h001);
    q_push(0, mk(9'h011, 8, 1'b1, 1'b0, 1, 2, 1'b1));
    push(0, 9'h011);
    check("push_pop_same_edge", 32'(bus_a.out_level), 32'd1);
    q_push(0, mk(9'h022, 8, 1'b1, 1'b0, 1, 2, 1'b1));
    push(0, 9'h022);
    q_push(0, mk(9'h033, 8, 1'b1, 1'b0, 1, 2, 1'b1));
    push(0, 9'h033);
    q_push(0, mk(9'h044, 8, 1'b1, 1'b0, 1, 2, 1'b1));
    push(0, 9'h044);
    check("full_level", 32'(bus_a.out_level), 32'd4);
    check("full_ready", 32'(bus_a.in_ready),  32'd0);
    q_push(0, mk(9'h055, 8, 1'b1, 1'b0, 1, 2, 1'b1));
    @(negedge clk);
    din[0] = 9'h055;
    vld[0] = 1'b1;
    cyc = 0;
    while (!bus_a.in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("recover_level", 32'(bus_a.out_level), 32'd3);
    @(posedge clk);
    #1 vld[0] = 1'b0;
    check("fifth_accepted", 32'(bus_a.out_level), 32'd4);
    wait_done(0, 400);

    // Divisor change mid-frame only affects the next frame.
    baud[0] = 16'd9;
    q_push(0, mk(9'h05A, 8, 1'b1, 1'b0, 1, 10, 1'b0));
    push(0, 9'h05A);
    repeat (30) @(negedge clk);
    baud[0] = 16'd1;
    q_push(0, mk(9'h007, 8, 1'b1, 1'b1, 1, 2, 1'b1));
    push(0, 9'h007);
    wait_done(0, 400);

    // Reset in the middle of DATA with two words still queued.
    baud[0] = 16'd3;
    q_push(0, mk(9'h05A, 8, 1'b1, 1'b0, 1, 4, 1'b0));
    push(0, 9'h05A);
    push(0, 9'h03C);
    push(0, 9'h081);
    repeat (10) @(negedge clk);
    check("pre_reset_level", 32'(bus_a.out_level), 32'd2);
    q0.delete();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_txd",   32'(bus_a.out_txd),   32'd1);
    check("mid_rst_level", 32'(bus_a.out_level), 32'd0);
    check("mid_rst_busy",  32'(bus_a.out_busy),  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_a.out_txd !== 1'b1 || bus_a.out_busy !== 1'b0 || bus_a.out_level !== 3'd0) bad++;
    end
    check("quiet_after_reset", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
